// File: rtl/sorted_list_streamer_pkg.sv
// Values shared by the insertion sorter and the sorted list streamer.
package sort_pkg;
  localparam int SORT_W = 8;
  localparam int SORT_N = 4;
  localparam logic [SORT_W-1:0] SORT_EMPTY = 8'hff;
  localparam int SORT_CW = $clog2(SORT_N + 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;
endpackage

// File: rtl/sorted_list_streamer_if.sv
// Load side and stream side of the sorted list streamer.
interface sorted_list_streamer_if
  import sort_pkg::*;
#(
  parameter int W  = SORT_W,
  parameter int CW = SORT_CW
);
  logic          load;
  logic [W-1:0]  in0;
  logic [W-1:0]  in1;
  logic [W-1:0]  in2;
  logic [W-1:0]  in3;
  logic          abort;
  logic          load_ready;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          done;
  logic [CW-1:0] count;

  modport master (
    output load, in0, in1, in2, in3, abort, out_ready,
    input  load_ready, out_data, out_valid, out_last, done, count
  );

  modport slave (
    input  load, in0, in1, in2, in3, abort, out_ready,
    output load_ready, out_data, out_valid, out_last, done, count
  );
endinterface

// File: rtl/sorted_list_streamer_first_empty_idx.sv
// Priority encoder: index of the lowest EMPTY entry, or N when the list is full.
module first_empty_idx
  import sort_pkg::*;
#(
  parameter int              W     = SORT_W,
  parameter int              N     = SORT_N,
  parameter logic [W-1:0]    EMPTY = SORT_EMPTY,
  parameter int              CW    = $clog2(N + 1)
) (
  input  logic [N-1:0][W-1:0] i_entries,
  output logic [CW-1:0]       o_idx
);
  logic [N-1:0] w_is_empty;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_cmp
      assign w_is_empty[gi] = (i_entries[gi] == EMPTY);
    end
  endgenerate

  // Scan from the top so the lowest matching index wins.
  always_comb begin
    o_idx = CW'(N);
    for (int i = N - 1; i >= 0; i--) begin
      if (w_is_empty[i]) o_idx = CW'(i);
    end
  end
endmodule

// File: rtl/sorted_list_streamer.sv
// Captures the sorter's four-entry list on load and streams its valid prefix
// out one entry per valid/ready handshake, then pulses done.
module sorted_list_streamer
  import sort_pkg::*;
#(
  parameter int           W     = SORT_W,
  parameter int           N     = SORT_N,
  parameter logic [W-1:0] EMPTY = SORT_EMPTY
) (
  input logic                  clk,
  input logic                  reset,
  sorted_list_streamer_if.slave bus
);
  localparam int CW = $clog2(N + 1);
  localparam int IW = $clog2(N);

  state_t               r_state;
  logic [W-1:0]         r_buf [N];
  logic [IW-1:0]        r_idx;
  logic [CW-1:0]        r_count;
  logic [W-1:0]         r_out_data;
  logic                 r_out_valid;
  logic                 r_out_last;
  logic                 r_done;
  logic                 r_load_ready;

  logic [N-1:0][W-1:0]  w_in;
  logic [CW-1:0]        w_first_empty;
  logic [IW-1:0]        w_idx_next;
  logic                 w_accept;

  assign w_in       = {bus.in3, bus.in2, bus.in1, bus.in0};
  assign w_idx_next = r_idx + IW'(1);
  assign w_accept   = r_out_valid & bus.out_ready;

  first_empty_idx #(
    .W     (W),
    .N     (N),
    .EMPTY (EMPTY),
    .CW    (CW)
  ) u_first_empty (
    .i_entries (w_in),
    .o_idx     (w_first_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_count      <= '0;
      r_out_data   <= EMPTY;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_done       <= 1'b0;
      r_load_ready <= 1'b1;
      for (int i = 0; i < N; i++) r_buf[i] <= EMPTY;
    end else begin
      r_done <= 1'b0;
      if (bus.abort) begin
        r_state      <= IDLE;
        r_idx        <= '0;
        r_count      <= '0;
        r_out_data   <= EMPTY;
        r_out_valid  <= 1'b0;
        r_out_last   <= 1'b0;
        r_load_ready <= 1'b1;
        for (int i = 0; i < N; i++) r_buf[i] <= EMPTY;
      end else begin
        case (r_state)
          IDLE: begin
            if (bus.load) begin
              for (int i = 0; i < N; i++) r_buf[i] <= w_in[i];
              r_count <= w_first_empty;
              r_idx   <= '0;
              // An empty list never enters SEND; it completes immediately.
              if (w_first_empty != '0) begin
                r_state      <= SEND;
                r_out_valid  <= 1'b1;
                r_out_data   <= bus.in0;
                r_out_last   <= (w_first_empty == CW'(1));
                r_load_ready <= 1'b0;
              end else begin
                r_done <= 1'b1;
              end
            end
          end
          SEND: begin
            if (w_accept) begin
              if (r_out_last) begin
                r_state      <= IDLE;
                r_out_valid  <= 1'b0;
                r_out_last   <= 1'b0;
                r_out_data   <= EMPTY;
                r_done       <= 1'b1;
                r_load_ready <= 1'b1;
              end else begin
                r_idx      <= w_idx_next;
                r_out_data <= r_buf[w_idx_next];
                r_out_last <= (CW'(w_idx_next) == r_count - CW'(1));
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.load_ready = r_load_ready;
  assign bus.out_data   = r_out_data;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_last   = r_out_last;
  assign bus.done       = r_done;
  assign bus.count      = r_count;
endmodule

// File: tb/tb_sorted_list_streamer.sv
// Self-checking bench for sorted_list_streamer against a queue-based list model.
module tb_sorted_list_streamer;
  import sort_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  sorted_list_streamer_if bus ();

  sorted_list_streamer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int         n_pass = 0;
  int         n_total = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  bit         last_q[$];
  int         done_cyc;
  int         stab_err;
  bit         saw_valid;
  logic       lr_at_done;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: the stream is the list prefix before the first EMPTY.
  function automatic void model(input logic [7:0] a, b, c, d);
    logic [7:0] l [4];
    l = '{a, b, c, d};
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      if (l[i] == 8'hff) break;
      exp_q.push_back(l[i]);
    end
  endfunction

  task automatic do_load(input logic [7:0] a, b, c, d);
    model(a, b, c, d);
    bus.in0 = a; bus.in1 = b; bus.in2 = c; bus.in3 = d;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    $display("load  %h %h %h %h  expect %0d entries", a, b, c, d, exp_q.size());
  endtask

  // Drains the stream until done (bounded), recording beats and hold violations.
  task automatic collect(input bit rnd);
    bit         prev_hold = 1'b0;
    logic [7:0] prev_data = '0;
    logic       prev_last = 1'b0;
    bit         rdy;
    got_q.delete();
    last_q.delete();
    done_cyc   = -1;
    stab_err   = 0;
    saw_valid  = 1'b0;
    lr_at_done = 1'b0;
    for (int c = 1; c <= 64; c++) begin
      if (prev_hold && (bus.out_valid !== 1'b1 || bus.out_data !== prev_data ||
                        bus.out_last !== prev_last))
        stab_err++;
      if (bus.done === 1'b1) begin
        done_cyc   = c;
        lr_at_done = bus.load_ready;
        break;
      end
      if (bus.out_valid === 1'b1) saw_valid = 1'b1;
      rdy = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.out_ready = rdy;
      if (bus.out_valid === 1'b1 && rdy) begin
        got_q.push_back(bus.out_data);
        last_q.push_back(bus.out_last);
        $display("beat  data=%h last=%b cycle=%0d", bus.out_data, bus.out_last, c);
      end
      prev_hold = (bus.out_valid === 1'b1) && !rdy;
      prev_data = bus.out_data;
      prev_last = bus.out_last;
      step();
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.load = 1'b0; bus.abort = 1'b0; bus.out_ready = 1'b0;
    bus.in0 = '0; bus.in1 = '0; bus.in2 = '0; bus.in3 = '0;
    reset = 1'b0;
    step();
    step();
    n_total++; if (bus.out_data !== 8'hff) $display("FAIL rst_data: got %h want ff", bus.out_data); else n_pass++;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", bus.out_valid); else n_pass++;
    n_total++; if (bus.load_ready !== 1'b1) $display("FAIL rst_load_ready: got %b want 1", bus.load_ready); else n_pass++;
    n_total++; if (bus.count !== 3'd0) $display("FAIL rst_count: got %0d want 0", bus.count); else n_pass++;
    n_total++; if (bus.done !== 1'b0) $display("FAIL rst_done: got %b want 0", bus.done); else n_pass++;
    n_total++; if (bus.out_last !== 1'b0) $display("FAIL rst_last: got %b want 0", bus.out_last); else n_pass++;
    reset = 1'b1;
    step();
  endtask

  task automatic test_full();
    do_load(8'h03, 8'h07, 8'h0a, 8'h20);
    n_total++; if (bus.count !== 3'd4) $display("FAIL full_count: got %0d want 4", bus.count); else n_pass++;
    n_total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h03) $display("FAIL full_first: got v=%b d=%h want v=1 d=03", bus.out_valid, bus.out_data); else n_pass++;
    collect(1'b0);
    n_total++; if (got_q.size() != exp_q.size()) $display("FAIL full_len: got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_total++; if (got_q[i] !== exp_q[i]) $display("FAIL full_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]); else n_pass++;
      n_total++; if (last_q[i] !== (i == exp_q.size() - 1)) $display("FAIL full_last[%0d]: got %b want %b", i, last_q[i], (i == exp_q.size() - 1)); else n_pass++;
    end
    n_total++; if (done_cyc != exp_q.size() + 1) $display("FAIL full_done_cycle: got %0d want %0d", done_cyc, exp_q.size() + 1); else n_pass++;
    n_total++; if (lr_at_done !== 1'b1) $display("FAIL full_ready_at_done: got %b want 1", lr_at_done); else n_pass++;
    step();
    n_total++; if (bus.done !== 1'b0) $display("FAIL full_done_width: got %b want 0", bus.done); else n_pass++;
    n_total++; if (bus.count !== 3'd4) $display("FAIL full_count_hold: got %0d want 4", bus.count); else n_pass++;
  endtask

  task automatic test_partial();
    do_load(8'h05, 8'h09, 8'hff, 8'hff);
    n_total++; if (bus.count !== 3'd2) $display("FAIL part_count: got %0d want 2", bus.count); else n_pass++;
    collect(1'b0);
    n_total++; if (got_q.size() != exp_q.size()) $display("FAIL part_len: got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_total++; if (got_q[i] !== exp_q[i]) $display("FAIL part_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]); else n_pass++;
      n_total++; if (last_q[i] !== (i == exp_q.size() - 1)) $display("FAIL part_last[%0d]: got %b want %b", i, last_q[i], (i == exp_q.size() - 1)); else n_pass++;
    end
    n_total++; if (done_cyc != 3) $display("FAIL part_done_cycle: got %0d want 3", done_cyc); else n_pass++;
    step();
  endtask

  task automatic test_all_empty();
    do_load(8'hff, 8'hff, 8'hff, 8'hff);
    n_total++; if (bus.count !== 3'd0) $display("FAIL empty_count: got %0d want 0", bus.count); else n_pass++;
    n_total++; if (bus.done !== 1'b1) $display("FAIL empty_done_next: got %b want 1", bus.done); else n_pass++;
    collect(1'b0);
    n_total++; if (saw_valid !== 1'b0) $display("FAIL empty_valid_seen: got %b want 0", saw_valid); else n_pass++;
    n_total++; if (done_cyc != 1) $display("FAIL empty_done_cycle: got %0d want 1", done_cyc); else n_pass++;
    step();
    n_total++; if (bus.done !== 1'b0 || bus.out_valid !== 1'b0) $display("FAIL empty_after: got done=%b v=%b want 0 0", bus.done, bus.out_valid); else n_pass++;
  endtask

  task automatic test_backpressure();
    do_load(8'h01, 8'h02, 8'h03, 8'h04);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      n_total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h02 || bus.out_last !== 1'b0) $display("FAIL bp_hold[%0d]: got v=%b d=%h l=%b want v=1 d=02 l=0", s, bus.out_valid, bus.out_data, bus.out_last); else n_pass++;
      if (s == 0) begin
        bus.in0 = 8'haa; bus.in1 = 8'hbb; bus.in2 = 8'hcc; bus.in3 = 8'hdd;
        bus.load = 1'b1;
      end
      step();
      bus.load = 1'b0;
    end
    n_total++; if (bus.out_data !== 8'h02 || bus.load_ready !== 1'b0) $display("FAIL bp_after_stall: got d=%h lr=%b want d=02 lr=0", bus.out_data, bus.load_ready); else n_pass++;
    exp_q = '{8'h02, 8'h03, 8'h04};
    collect(1'b0);
    n_total++; if (got_q.size() != exp_q.size()) $display("FAIL bp_len: got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_total++; if (got_q[i] !== exp_q[i]) $display("FAIL bp_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]); else n_pass++;
    end
    n_total++; if (bus.count !== 3'd4) $display("FAIL bp_count: got %0d want 4", bus.count); else n_pass++;
    step();
  endtask

  task automatic test_abort();
    do_load(8'h11, 8'h22, 8'h33, 8'h44);
    bus.out_ready = 1'b1;
    step();
    n_total++; if (bus.out_data !== 8'h22) $display("FAIL abort_entry1: got %h want 22", bus.out_data); else n_pass++;
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    bus.out_ready = 1'b0;
    n_total++; if (bus.out_valid !== 1'b0 || bus.done !== 1'b0) $display("FAIL abort_flush: got v=%b done=%b want 0 0", bus.out_valid, bus.done); else n_pass++;
    n_total++; if (bus.count !== 3'd0 || bus.load_ready !== 1'b1) $display("FAIL abort_idle: got count=%0d lr=%b want 0 1", bus.count, bus.load_ready); else n_pass++;
    n_total++; if (bus.out_data !== 8'hff) $display("FAIL abort_data: got %h want ff", bus.out_data); else n_pass++;
    step();
    n_total++; if (bus.done !== 1'b0 || bus.out_valid !== 1'b0) $display("FAIL abort_no_done: got done=%b v=%b want 0 0", bus.done, bus.out_valid); else n_pass++;
  endtask

  task automatic test_reset_mid_send();
    do_load(8'h10, 8'h20, 8'h30, 8'h40);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    reset = 1'b0;
    step();
    n_total++; if (bus.out_valid !== 1'b0 || bus.out_data !== 8'hff) $display("FAIL rmid_out: got v=%b d=%h want 0 ff", bus.out_valid, bus.out_data); else n_pass++;
    n_total++; if (bus.count !== 3'd0 || bus.load_ready !== 1'b1 || bus.done !== 1'b0) $display("FAIL rmid_state: got count=%0d lr=%b done=%b want 0 1 0", bus.count, bus.load_ready, bus.done); else n_pass++;
    reset = 1'b1;
    step();
    n_total++; if (bus.done !== 1'b0) $display("FAIL rmid_no_done: got %b want 0", bus.done); else n_pass++;
    do_load(8'h10, 8'hff, 8'hff, 8'hff);
    n_total++; if (bus.count !== 3'd1) $display("FAIL rmid_count: got %0d want 1", bus.count); else n_pass++;
    collect(1'b0);
    n_total++; if (got_q.size() != 1) $display("FAIL rmid_len: got %0d want 1", got_q.size()); else n_pass++;
    if (got_q.size() >= 1) begin
      n_total++; if (got_q[0] !== 8'h10 || last_q[0] !== 1'b1) $display("FAIL rmid_entry: got d=%h l=%b want 10 1", got_q[0], last_q[0]); else n_pass++;
    end
    n_total++; if (done_cyc != 2) $display("FAIL rmid_done_cycle: got %0d want 2", done_cyc); else n_pass++;
    step();
  endtask

  // Random lists and random backpressure; each new load lands in the done cycle.
  task automatic test_back_to_back();
    logic [7:0] v [4];
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < 4; i++)
        v[i] = ($urandom_range(0, 3) == 0) ? 8'hff : 8'($urandom_range(0, 254));
      n_total++; if (bus.load_ready !== 1'b1) $display("FAIL b2b_ready[%0d]: got %b want 1", it, bus.load_ready); else n_pass++;
      do_load(v[0], v[1], v[2], v[3]);
      n_total++; if (bus.count !== 3'(exp_q.size())) $display("FAIL b2b_count[%0d]: got %0d want %0d", it, bus.count, exp_q.size()); else n_pass++;
      collect(1'b1);
      n_total++; if (got_q.size() != exp_q.size()) $display("FAIL b2b_len[%0d]: got %0d want %0d", it, got_q.size(), exp_q.size()); else n_pass++;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        n_total++; if (got_q[i] !== exp_q[i] || last_q[i] !== (i == exp_q.size() - 1)) $display("FAIL b2b_beat[%0d.%0d]: got d=%h l=%b want d=%h l=%b", it, i, got_q[i], last_q[i], exp_q[i], (i == exp_q.size() - 1)); else n_pass++;
      end
      n_total++; if (done_cyc < 1) $display("FAIL b2b_timeout[%0d]: got no done want done", it); else n_pass++;
      n_total++; if (stab_err != 0) $display("FAIL b2b_hold[%0d]: got %0d violations want 0", it, stab_err); else n_pass++;
    end
    step();
  endtask

  initial begin
    test_reset();
    test_full();
    test_partial();
    test_all_empty();
    test_backpressure();
    test_abort();
    test_reset_mid_send();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
